// File: rtl/integrator_vth.sv
// integrator_vth -- gain-scaled, threshold-limited, saturating integrator.
//
// Each enabled update runs four states: DV (sample the error and build the
// increment), SUM (33-bit add), SAT (clamp into the accumulator), OUT (drive
// o_int, optionally adding an external signal). One update every 4 clocks.
//
// Ports:
//   i_clk, i_rst_n          clock (rising edge), async active-low reset
//   i_gain_mode, i_gain_sel 0 = right shift, 1 = left shift; shift amount
//   i_err                   signed error sample
//   i_en, i_zero            integration enable; synchronous clear
//   i_saturation            unsigned magnitude limit (capped at 0x7FFFFFFF)
//   i_add_sig_en, i_ext_sig add signed external signal to the output
//   i_vth, i_vth_cut        error threshold; step used when it is exceeded
//   o_int                   signed integrator output
//   o_*                     debug views of internal state (see declarations)
module integrator_vth (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_gain_mode,
  input  logic [5:0]  i_gain_sel,
  input  logic [31:0] i_err,
  input  logic        i_en,
  input  logic        i_zero,
  input  logic [31:0] i_saturation,
  input  logic        i_add_sig_en,
  input  logic [31:0] i_ext_sig,
  input  logic [31:0] i_vth,
  input  logic [31:0] i_vth_cut,
  output logic [31:0] o_int,
  output logic [31:0] o_sat_p,
  output logic [31:0] o_sat_n,
  output logic [31:0] o_vth_cut_p,
  output logic [31:0] o_vth_cut_n,
  output logic [3:0]  o_cstate,
  output logic [3:0]  o_nstate,
  output logic [31:0] o_dv,
  output logic [31:0] o_vo,
  output logic [4:0]  o_shift_idx,
  output logic        o_change,
  output logic        o_sat_flag_p,
  output logic        o_sat_flag_n,
  output logic        o_vth_flag_p,
  output logic        o_vth_flag_n,
  output logic        o_err_pol,
  output logic        o_err_pol_change,
  output logic        o_zero_flag
);

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    DV   = 4'd1,
    SUM  = 4'd2,
    SAT  = 4'd3,
    OUT  = 4'd4
  } state_t;

  state_t cstate, nstate;

  logic [31:0]        dv, vo, int_q;
  logic signed [32:0] sum_q;

  // Clamp a 33-bit signed value to the symmetric range [-lim, +lim].
  function automatic logic [31:0] clamp_sym(input logic signed [32:0] x,
                                            input logic [31:0]        lim);
    logic signed [32:0] hi;
    hi = $signed({1'b0, lim});
    if (x > hi)       return lim;
    else if (x < -hi) return -lim;
    else              return x[31:0];
  endfunction

  // Next-state logic.
  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    nstate = cstate;
    case (cstate)
      IDLE:    if (i_en) nstate = DV;
      DV:      nstate = SUM;
      SUM:     nstate = SAT;
      SAT:     nstate = OUT;
      OUT:     nstate = i_en ? DV : IDLE;
      default: nstate = IDLE;
    endcase
  end

  // Datapath terms evaluated from the live inputs; only the state that
  // owns each term registers it.
  logic [31:0]        sat_lim;
  logic [4:0]         shift_n;
  logic signed [33:0] err_x, vth_x;
  logic               vth_p_n, vth_n_n;
  logic signed [31:0] err_s;
  logic signed [63:0] amp;
  logic [31:0]        dv_n;
  logic signed [32:0] sum_n, out_n, sat_hi;
  logic               over, under;

  always_comb begin
    sat_lim = i_saturation[31] ? 32'h7FFF_FFFF : i_saturation;
    shift_n = (i_gain_sel > 6'd31) ? 5'd31 : i_gain_sel[4:0];

    // 34-bit compare so that the negated unsigned threshold cannot wrap.
    err_x   = {{2{i_err[31]}}, i_err};
    vth_x   = {2'b00, i_vth};
    vth_p_n = err_x > vth_x;
    vth_n_n = err_x < -vth_x;

    err_s = i_err;
    amp   = $signed({{32{i_err[31]}}, i_err}) <<< shift_n;

    dv_n = 32'd0;
    if (vth_p_n)           dv_n = i_vth_cut;
    else if (vth_n_n)      dv_n = -i_vth_cut;
    else if (!i_gain_mode) dv_n = err_s >>> shift_n;
    else if (amp > 64'sh0000_0000_7FFF_FFFF) dv_n = 32'h7FFF_FFFF;
    else if (amp < 64'shFFFF_FFFF_8000_0000) dv_n = 32'h8000_0000;
    else                   dv_n = amp[31:0];

    sum_n  = $signed({dv[31], dv}) + $signed({vo[31], vo});
    out_n  = $signed({vo[31], vo}) + $signed({i_ext_sig[31], i_ext_sig});
    sat_hi = $signed({1'b0, sat_lim});
    over   = sum_q > sat_hi;
    under  = sum_q < -sat_hi;
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  // NOTE: the asynchronous reset clears every register, so an update that
  // is interrupted by reset leaves nothing partial behind.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cstate           <= IDLE;
      o_shift_idx      <= '0;
      o_change         <= 1'b0;
      o_err_pol        <= 1'b0;
      o_err_pol_change <= 1'b0;
      o_vth_flag_p     <= 1'b0;
      o_vth_flag_n     <= 1'b0;
      o_sat_flag_p     <= 1'b0;
      o_sat_flag_n     <= 1'b0;
      dv               <= '0;
      sum_q            <= '0;
      vo               <= '0;
      int_q            <= '0;
      o_sat_p          <= '0;
      o_sat_n          <= '0;
      o_vth_cut_p      <= '0;
      o_vth_cut_n      <= '0;
      o_zero_flag      <= 1'b0;
    end else begin
      cstate           <= nstate;
      o_sat_p          <= sat_lim;
      o_sat_n          <= -sat_lim;
      o_vth_cut_p      <= i_vth_cut;
      o_vth_cut_n      <= -i_vth_cut;
      o_zero_flag      <= i_zero;
      o_change         <= 1'b0;
      o_err_pol_change <= 1'b0;

      case (cstate)
        DV: begin
          o_shift_idx      <= shift_n;
          o_change         <= (shift_n != o_shift_idx);
          o_err_pol        <= i_err[31];
          o_err_pol_change <= (i_err[31] != o_err_pol);
          o_vth_flag_p     <= vth_p_n;
          o_vth_flag_n     <= vth_n_n;
          dv               <= dv_n;
        end
        SUM: sum_q <= sum_n;
        SAT: begin
          vo           <= clamp_sym(sum_q, sat_lim);
          o_sat_flag_p <= over;
          o_sat_flag_n <= under;
        end
        OUT: int_q <= i_add_sig_en ? clamp_sym(out_n, sat_lim) : vo;
        default: ;
      endcase

      // Clear wins over any update in flight, including a pending sum.
      if (i_zero) begin
        vo    <= '0;
        dv    <= '0;
        sum_q <= '0;
        int_q <= '0;
      end
    end
  end

  assign o_cstate = cstate;
  assign o_nstate = nstate;
  assign o_dv     = dv;
  assign o_vo     = vo;
  assign o_int    = int_q;

endmodule

// File: tb/tb_integrator_vth.sv
// Directed testbench for integrator_vth. Inputs change 1 time unit after a
// rising edge and outputs are sampled at that same point.
module tb_integrator_vth;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_gain_mode;
  logic [5:0]  i_gain_sel;
  logic [31:0] i_err;
  logic        i_en;
  logic        i_zero;
  logic [31:0] i_saturation;
  logic        i_add_sig_en;
  logic [31:0] i_ext_sig;
  logic [31:0] i_vth;
  logic [31:0] i_vth_cut;
  logic [31:0] o_int, o_sat_p, o_sat_n, o_vth_cut_p, o_vth_cut_n, o_dv, o_vo;
  logic [3:0]  o_cstate, o_nstate;
  logic [4:0]  o_shift_idx;
  logic        o_change, o_sat_flag_p, o_sat_flag_n, o_vth_flag_p, o_vth_flag_n;
  logic        o_err_pol, o_err_pol_change, o_zero_flag;

  int checks   = 0;
  int failures = 0;
  logic [31:0] held;

  always #5 i_clk = ~i_clk;

  integrator_vth dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_gain_mode(i_gain_mode),
    .i_gain_sel(i_gain_sel), .i_err(i_err), .i_en(i_en), .i_zero(i_zero),
    .i_saturation(i_saturation), .i_add_sig_en(i_add_sig_en),
    .i_ext_sig(i_ext_sig), .i_vth(i_vth), .i_vth_cut(i_vth_cut),
    .o_int(o_int), .o_sat_p(o_sat_p), .o_sat_n(o_sat_n),
    .o_vth_cut_p(o_vth_cut_p), .o_vth_cut_n(o_vth_cut_n),
    .o_cstate(o_cstate), .o_nstate(o_nstate), .o_dv(o_dv), .o_vo(o_vo),
    .o_shift_idx(o_shift_idx), .o_change(o_change),
    .o_sat_flag_p(o_sat_flag_p), .o_sat_flag_n(o_sat_flag_n),
    .o_vth_flag_p(o_vth_flag_p), .o_vth_flag_n(o_vth_flag_n),
    .o_err_pol(o_err_pol), .o_err_pol_change(o_err_pol_change),
    .o_zero_flag(o_zero_flag)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d (0x%08h) expected=%0d (0x%08h)",
             tag, $signed(obs), obs, $signed(exp), exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Advance until n OUT states have completed, with a bounded cycle budget.
  task automatic run_updates(input int n);
    int done = 0;
    int cyc  = 0;
    logic [3:0] st;
    while (done < n && cyc < 8 * n + 16) begin
      st = o_cstate;
      tick();
      cyc++;
      if (st == 4'd4) done++;
    end
    check("update_budget", done, n);
  endtask

  initial begin
    i_rst_n = 1'b0; i_gain_mode = 1'b0; i_gain_sel = 6'd0; i_err = -30;
    i_en = 1'b0; i_zero = 1'b0; i_saturation = 1000000; i_add_sig_en = 1'b0;
    i_ext_sig = 0; i_vth = 1000; i_vth_cut = 1000;

    // Reset state.
    tick(); tick();
    check("rst_int",    o_int, 0);
    check("rst_cstate", 32'(o_cstate), 0);
    check("rst_sat_p",  o_sat_p, 0);
    i_rst_n = 1'b1;
    tick();
    check("idle_no_en",  32'(o_cstate), 0);
    check("sat_p",       o_sat_p, 1000000);
    check("sat_n",       o_sat_n, -1000000);
    check("vth_cut_n",   o_vth_cut_n, -1000);

    // Baseline: -30 per update, 20 updates.
    i_en = 1'b1;
    tick();
    check("first_dv",    32'(o_cstate), 1);
    check("nstate_sum",  32'(o_nstate), 2);
    run_updates(20);
    check("int_20",      o_int, -600);
    check("err_pol_neg", 32'(o_err_pol), 1);
    check("dv_base",     o_dv, -30);

    // Shift changes.
    i_gain_sel = 6'd1;
    tick();
    check("change_pulse", 32'(o_change), 1);
    check("shift_1",      32'(o_shift_idx), 1);
    check("dv_shift1",    o_dv, -15);
    tick();
    check("change_once",  32'(o_change), 0);
    run_updates(1);
    check("int_shift1",   o_int, -615);
    i_gain_sel = 6'd2;
    tick();
    check("dv_shift2",    o_dv, -8);
    run_updates(1);
    check("int_shift2",   o_int, -623);

    // Polarity change.
    i_gain_sel = 6'd0; i_err = 30;
    tick();
    check("pol_change",   32'(o_err_pol_change), 1);
    check("err_pol_pos",  32'(o_err_pol), 0);
    check("dv_pos",       o_dv, 30);
    tick();
    check("pol_once",     32'(o_err_pol_change), 0);
    run_updates(1);
    check("int_pos1",     o_int, -593);
    run_updates(1);
    check("int_pos2",     o_int, -563);

    // Amplifying gain: shift capped at 31, product clamped to int32 max.
    i_gain_mode = 1'b1; i_gain_sel = 6'd40;
    tick();
    check("shift_cap",    32'(o_shift_idx), 31);
    check("dv_amp_clamp", o_dv, 32'h7FFF_FFFF);
    run_updates(1);
    check("int_amp_sat",  o_int, 1000000);
    check("sat_flag_amp", 32'(o_sat_flag_p), 1);
    i_gain_sel = 6'd3; i_err = -30;
    tick();
    check("dv_amp3",      o_dv, -240);
    run_updates(1);
    check("int_amp3",     o_int, 999760);
    check("sat_flag_clr", 32'(o_sat_flag_p), 0);

    // Threshold cut, including the strict boundaries.
    i_gain_mode = 1'b0; i_gain_sel = 6'd0; i_err = 5000;
    tick();
    check("vth_flag_p",   32'(o_vth_flag_p), 1);
    check("dv_vth_p",     o_dv, 1000);
    run_updates(1);
    check("int_vth_p",    o_int, 1000000);
    i_err = -5000;
    tick();
    check("vth_flag_n",   32'(o_vth_flag_n), 1);
    check("vth_p_clr",    32'(o_vth_flag_p), 0);
    check("dv_vth_n",     o_dv, -1000);
    run_updates(1);
    check("int_vth_n",    o_int, 999000);
    i_err = 1000; i_gain_sel = 6'd1;
    tick();
    check("vth_p_edge",   32'(o_vth_flag_p), 0);
    check("dv_edge_p",    o_dv, 500);
    run_updates(1);
    i_err = -1000;
    tick();
    check("vth_n_edge",   32'(o_vth_flag_n), 0);
    check("dv_edge_n",    o_dv, -500);
    run_updates(1);
    check("int_edges",    o_int, 999000);

    // Saturation and external signal.
    i_saturation = 100; i_err = 30; i_gain_sel = 6'd0;
    run_updates(1);
    check("int_sat100",   o_int, 100);
    check("sat_flag_p",   32'(o_sat_flag_p), 1);
    run_updates(1);
    check("int_sat_hold", o_int, 100);
    i_add_sig_en = 1'b1; i_ext_sig = -50;
    run_updates(1);
    check("int_ext50",    o_int, 50);
    i_ext_sig = -500;
    run_updates(1);
    check("int_ext_clamp", o_int, -100);
    i_add_sig_en = 1'b0; i_err = -5000;
    run_updates(1);
    check("vo_sat_n",     o_vo, -100);
    check("sat_flag_n",   32'(o_sat_flag_n), 1);
    check("sat_flag_p0",  32'(o_sat_flag_p), 0);

    // Disable: current update completes, then the FSM parks.
    i_en = 1'b0; i_err = 30;
    run_updates(1);
    check("int_last",     o_int, -70);
    check("park_idle",    32'(o_cstate), 0);
    held = o_int;
    repeat (20) tick();
    check("int_held",     o_int, -70);
    check("idle_held",    32'(o_cstate), 0);
    check("vo_held",      o_vo, held);

    // Zero.
    i_zero = 1'b1;
    tick();
    i_zero = 1'b0;
    check("zero_int",     o_int, 0);
    check("zero_vo",      o_vo, 0);
    check("zero_dv",      o_dv, 0);
    check("zero_flag",    32'(o_zero_flag), 1);
    tick();
    check("zero_flag_clr", 32'(o_zero_flag), 0);

    // Reset in the middle of an update.
    i_en = 1'b1;
    tick();
    run_updates(2);
    check("int_restart",  o_int, 60);
    tick(); tick();
    #2;
    i_rst_n = 1'b0;
    #1;
    check("mid_rst_vo",   o_vo, 0);
    check("mid_rst_int",  o_int, 0);
    check("mid_rst_dv",   o_dv, 0);
    check("mid_rst_st",   32'(o_cstate), 0);
    tick();
    i_rst_n = 1'b1; i_en = 1'b0; i_saturation = 32'hFFFF_FFFF;
    tick();
    check("sat_cap_p",    o_sat_p, 32'h7FFF_FFFF);
    check("sat_cap_n",    o_sat_n, 32'h8000_0001);
    check("rst_park",     32'(o_cstate), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/integrator_vth.md
INTEGRATOR_VTH -- requirements
Module: integrator_vth

Interface
REQ-001 SHALL have the following ports (name  direction  width  meaning):
- i_clk  in  1  sole clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_gain_mode  in  1  0 = attenuating gain (right shift), 1 = amplifying gain (left shift).
- i_gain_sel  in  6  requested shift amount.
- i_err  in  32  signed error sample.
- i_en  in  1  integration enable.
- i_zero  in  1  synchronous clear of the integrator.
- i_saturation  in  32  unsigned magnitude limit.
- i_add_sig_en  in  1  add the external signal to the output.
- i_ext_sig  in  32  signed external signal.
- i_vth  in  32  unsigned error threshold.
- i_vth_cut  in  32  unsigned step applied when the threshold is exceeded.
- o_int  out  32  signed integrator output.
- Debug outputs:
  - o_sat_p, o_sat_n (32): registered +i_saturation and -i_saturation.
  - o_vth_cut_p, o_vth_cut_n (32): registered +i_vth_cut and -i_vth_cut.
  - o_cstate, o_nstate (4): current and next FSM state.
  - o_dv (32): last increment.
  - o_vo (32): accumulator.
  - o_shift_idx (5): applied shift.
  - o_change (1): pulse when the shift changes.
  - o_sat_flag_p, o_sat_flag_n (1): saturation flags.
  - o_vth_flag_p, o_vth_flag_n (1): threshold flags.
  - o_err_pol (1): 1 when the latched error is negative.
  - o_err_pol_change (1): pulse when the error polarity changes.
  - o_zero_flag (1): registered i_zero.

Function
REQ-002 The FSM SHALL use these states: IDLE=0, DV=1, SUM=2, SAT=3, OUT=4.
REQ-003 FSM transitions SHALL be IDLE->DV when i_en=1; DV->SUM->SAT->OUT->DV unconditionally; any state->IDLE when i_en=0 at the end of OUT or while in IDLE.
- One integration update completes every 4 clocks while enabled.
- o_nstate is combinational; o_cstate is registered.
REQ-004 In DV, the block SHALL latch i_err and compute o_shift_idx = min(i_gain_sel,31).
REQ-005 In DV, if the new o_shift_idx differs from the previous one, o_change SHALL be 1 for exactly one clock.
REQ-006 In DV, o_err_pol SHALL take i_err[31]; o_err_pol_change SHALL pulse for one clock when o_err_pol changes.
REQ-007 Threshold flags in DV SHALL be o_vth_flag_p = (signed err > +i_vth) and o_vth_flag_n = (signed err < -i_vth), with strict comparisons.
REQ-008 The increment dv SHALL be:
- +i_vth_cut if o_vth_flag_p;
- -i_vth_cut if o_vth_flag_n;
- else err >>> shift_idx (arithmetic) when i_gain_mode=0;
- else err <<< shift_idx when i_gain_mode=1, computed at 64 bits and clamped to the signed 32-bit range.
REQ-009 In SUM, sum = vo + dv SHALL be computed at 33 bits, with no wrap-around.
REQ-010 In SAT, vo SHALL be clamped as follows:
- If sum > +i_saturation: vo = +i_saturation and o_sat_flag_p=1.
- If sum < -i_saturation: vo = -i_saturation and o_sat_flag_n=1.
- Otherwise vo = sum and both flags are 0.
- Flags hold until the next SAT state.
REQ-011 In OUT, o_int SHALL be vo + i_ext_sig when i_add_sig_en=1 (the 33-bit result clamped to ±i_saturation), otherwise o_int = vo.
REQ-012 i_zero=1 SHALL clear vo, o_dv and o_int to 0 on the next clock regardless of state and take priority over any update; o_zero_flag follows i_zero with 1-clock latency.
REQ-013 With i_en=0, vo and o_int SHALL hold their values; the FSM completes the current update, then parks in IDLE.
REQ-014 i_saturation SHALL be treated as at most 0x7FFFFFFF; larger values saturate to 0x7FFFFFFF.
REQ-015 o_sat_p, o_sat_n, o_vth_cut_p and o_vth_cut_n SHALL update every clock.
REQ-016 Inputs SHALL be sampled only in the states named above; changes mid-update take effect at the next DV.

Reset
REQ-017 While i_rst_n=0, all outputs and internal registers SHALL be 0 and the FSM SHALL be in IDLE, asynchronously.
REQ-018 After release, the first DV state SHALL occur on the first clock on which i_en=1.
REQ-019 An asserted reset mid-update SHALL abort the update with no partial result retained.

Verification
REQ-020 Scenario: reset, then i_err=-30, i_gain_sel=0, i_gain_mode=0, i_en=1, i_saturation=1000000, i_vth=i_vth_cut=1000 -> vo steps by -30 every 4 clocks; after 20 updates o_int=-600; o_err_pol=1.
REQ-021 Scenario: i_gain_sel 0->1 -> o_change pulses once, o_shift_idx=1, o_dv=-15; i_gain_sel=2 -> o_dv=-8.
REQ-022 Scenario: i_err -30->+30 -> o_err_pol_change pulses once, o_err_pol=0, vo increases by 30 per update.
REQ-023 Scenario: i_err=5000 -> o_vth_flag_p=1, o_dv=+1000; i_err=-5000 -> o_vth_flag_n=1, o_dv=-1000.
REQ-024 Scenario: i_saturation=100, i_err=30 -> o_int stops at 100 and o_sat_flag_p=1; i_add_sig_en=1 with i_ext_sig=-50 -> o_int=50.
REQ-025 Scenario: i_en=0 for 20 clocks -> o_int constant and FSM in IDLE; i_zero=1 for 1 clock -> o_int=0 next clock and o_zero_flag=1.
